// File: rtl/bsc_axis_accid_demux.sv
// bsc_axis_accid_demux
// Routes AXI-Stream packets to one of NUM_ACCS accelerator ports, chosen by
// the tid of the first beat of each packet. Packets whose tid names no
// existing port are dropped and reported on bad_id_pulse.
//
// Datapath: 2-entry skid buffer -> routing FSM -> single output register.
// The output register is shared by all ports; only tvalid is steered.
//
// Optional build macro ACCID_DEMUX_ERR_CNT_EN adds a 16-bit saturating
// dropped-packet counter on output bad_id_count.
module bsc_axis_accid_demux #(
    parameter int NUM_ACCS = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              S_AXIS_tdata,
    input  logic [1:0]               S_AXIS_tdest,
    input  logic [ID_WIDTH-1:0]      S_AXIS_tid,
    input  logic                     S_AXIS_tlast,
    input  logic                     S_AXIS_tvalid,
    output logic                     S_AXIS_tready,
    output logic [NUM_ACCS*64-1:0]   M_AXIS_tdata,
    output logic [NUM_ACCS*2-1:0]    M_AXIS_tdest,
    output logic [NUM_ACCS-1:0]      M_AXIS_tlast,
    output logic [NUM_ACCS-1:0]      M_AXIS_tvalid,
    input  logic [NUM_ACCS-1:0]      M_AXIS_tready,
    output logic                     bad_id_pulse
`ifdef ACCID_DEMUX_ERR_CNT_EN
    ,
    output logic [15:0]              bad_id_count
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUTE = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    localparam logic [ID_WIDTH:0] NUM_ACCS_L = (ID_WIDTH+1)'(NUM_ACCS);

    // skid buffer
    logic [63:0]         buf_data_q [2];
    logic [1:0]          buf_dest_q [2];
    logic [ID_WIDTH-1:0] buf_id_q   [2];
    logic                buf_last_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          cnt_q;
    logic [1:0]          cnt_d;
    logic                s_ready_q;

    // output register
    logic [63:0]         out_data_q;
    logic [1:0]          out_dest_q;
    logic                out_last_q;
    logic [NUM_ACCS-1:0] out_valid_q;
    logic [NUM_ACCS-1:0] port_q;
    logic                bad_pulse_q;

    logic [1:0]          state_q;
    logic [1:0]          state_d;

    // combinational helpers
    logic                accept_s;
    logic                head_vld_s;
    logic [63:0]         head_data_s;
    logic [1:0]          head_dest_s;
    logic [ID_WIDTH-1:0] head_id_s;
    logic                head_last_s;
    logic                head_ok_s;
    logic [NUM_ACCS-1:0] head_onehot_s;
    logic                out_busy_s;
    logic                out_hs_s;
    logic                out_free_s;
    logic                tail_pending_s;
    logic                load_s;
    logic                bad_s;
    logic                pop_s;
    logic                first_s;
    logic [NUM_ACCS-1:0] new_port_s;

    assign accept_s       = S_AXIS_tvalid & s_ready_q;
    assign head_vld_s     = (cnt_q != 2'd0);
    assign head_data_s    = buf_data_q[rd_ptr_q];
    assign head_dest_s    = buf_dest_q[rd_ptr_q];
    assign head_id_s      = buf_id_q[rd_ptr_q];
    assign head_last_s    = buf_last_q[rd_ptr_q];
    assign head_ok_s      = ({1'b0, head_id_s} < NUM_ACCS_L);
    assign out_busy_s     = |out_valid_q;
    assign out_hs_s       = |(out_valid_q & M_AXIS_tready);
    assign out_free_s     = ~out_busy_s | out_hs_s;
    // the tail of the current packet already sits in the output register
    assign tail_pending_s = out_busy_s & out_last_q;

    // decode the head beat's tid into a one-hot port select
    always_comb begin
        head_onehot_s = '0;
        for (int k = 0; k < NUM_ACCS; k++) begin
            head_onehot_s[k] = (head_id_s == ID_WIDTH'(k));
        end
    end

    // packet FSM: decides whether the head beat is loaded, dropped or held
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        bad_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_vld_s) begin
                    if (head_ok_s) begin
                        load_s  = out_free_s;
                        state_d = out_free_s ? ST_ROUTE : ST_IDLE;
                    end else begin
                        bad_s   = 1'b1;
                        state_d = head_last_s ? ST_IDLE : ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUTE: begin
                if (tail_pending_s) begin
                    // head (if any) starts the next packet, once the tail leaves
                    if (out_hs_s && head_vld_s) begin
                        if (head_ok_s) begin
                            load_s  = 1'b1;
                            state_d = ST_ROUTE;
                        end else begin
                            bad_s   = 1'b1;
                            state_d = head_last_s ? ST_IDLE : ST_DROP;
                        end
                    end else if (out_hs_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ROUTE;
                    end
                end else begin
                    // continuation beat: tid ignored, goes to the latched port
                    load_s  = head_vld_s & out_free_s;
                    state_d = ST_ROUTE;
                end
            end
            ST_DROP: begin
                if (head_vld_s) begin
                    state_d = head_last_s ? ST_IDLE : ST_DROP;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pop_s      = load_s | bad_s | ((state_q == ST_DROP) & head_vld_s);
    assign first_s    = load_s & ((state_q != ST_ROUTE) | tail_pending_s);
    assign new_port_s = first_s ? head_onehot_s : port_q;
    assign cnt_d      = cnt_q + {1'b0, accept_s} - {1'b0, pop_s};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // skid buffer storage, pointers, occupancy and registered input ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            s_ready_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= 64'd0;
                buf_dest_q[i] <= 2'd0;
                buf_id_q[i]   <= '0;
                buf_last_q[i] <= 1'b0;
            end
        end else begin
            if (accept_s) begin
                buf_data_q[wr_ptr_q] <= S_AXIS_tdata;
                buf_dest_q[wr_ptr_q] <= S_AXIS_tdest;
                buf_id_q[wr_ptr_q]   <= S_AXIS_tid;
                buf_last_q[wr_ptr_q] <= S_AXIS_tlast;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q     <= cnt_d;
            s_ready_q <= (cnt_d != 2'd2);
        end
    end

    // output register: load a routed beat, or clear after handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= 64'd0;
            out_dest_q  <= 2'd0;
            out_last_q  <= 1'b0;
            out_valid_q <= '0;
            port_q      <= '0;
        end else if (load_s) begin
            out_data_q  <= head_data_s;
            out_dest_q  <= head_dest_s;
            out_last_q  <= head_last_s;
            out_valid_q <= new_port_s;
            port_q      <= new_port_s;
        end else if (out_hs_s) begin
            out_valid_q <= '0;
        end
    end

    // one-cycle pulse for each dropped packet
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_pulse_q <= 1'b0;
        end else begin
            bad_pulse_q <= bad_s;
        end
    end

`ifdef ACCID_DEMUX_ERR_CNT_EN
    logic [15:0] bad_cnt_q;

    // saturating dropped-packet counter
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_cnt_q <= 16'd0;
        end else if (bad_s && (bad_cnt_q != 16'hFFFF)) begin
            bad_cnt_q <= bad_cnt_q + 16'd1;
        end
    end

    assign bad_id_count = bad_cnt_q;
`endif

    assign S_AXIS_tready = s_ready_q;
    assign M_AXIS_tdata  = {NUM_ACCS{out_data_q}};
    assign M_AXIS_tdest  = {NUM_ACCS{out_dest_q}};
    assign M_AXIS_tlast  = {NUM_ACCS{out_last_q}};
    assign M_AXIS_tvalid = out_valid_q;
    assign bad_id_pulse  = bad_pulse_q;

endmodule

// File: tb/tb_bsc_axis_accid_demux.sv
// Directed bench for bsc_axis_accid_demux (NUM_ACCS=4, ID_WIDTH=3 so that
// out-of-range tids 4..7 exist). Expected beats are queued when driven and
// matched by a monitor on every output handshake.
module tb_bsc_axis_accid_demux;

    localparam int NA = 4;
    localparam int IW = 3;

    typedef struct packed {
        logic [3:0]  port;
        logic [63:0] data;
        logic [1:0]  dest;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [63:0]       S_AXIS_tdata;
    logic [1:0]        S_AXIS_tdest;
    logic [IW-1:0]     S_AXIS_tid;
    logic              S_AXIS_tlast;
    logic              S_AXIS_tvalid;
    logic              S_AXIS_tready;
    logic [NA*64-1:0]  M_AXIS_tdata;
    logic [NA*2-1:0]   M_AXIS_tdest;
    logic [NA-1:0]     M_AXIS_tlast;
    logic [NA-1:0]     M_AXIS_tvalid;
    logic [NA-1:0]     M_AXIS_tready;
    logic              bad_id_pulse;
`ifdef ACCID_DEMUX_ERR_CNT_EN
    logic [15:0]       bad_id_count;
`endif

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    beat_t exp_q[$];
    int    hs_q[$];
    int    bad_seen = 0;
    bit    saw_full = 1'b0;
    bit    tog_en = 1'b0;
    int    tog_idx = 0;
    logic [3:0] tog_pat = 4'b1001;

    bsc_axis_accid_demux #(
        .NUM_ACCS(NA),
        .ID_WIDTH(IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .S_AXIS_tdata (S_AXIS_tdata),
        .S_AXIS_tdest (S_AXIS_tdest),
        .S_AXIS_tid   (S_AXIS_tid),
        .S_AXIS_tlast (S_AXIS_tlast),
        .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tdata (M_AXIS_tdata),
        .M_AXIS_tdest (M_AXIS_tdest),
        .M_AXIS_tlast (M_AXIS_tlast),
        .M_AXIS_tvalid(M_AXIS_tvalid),
        .M_AXIS_tready(M_AXIS_tready),
        .bad_id_pulse (bad_id_pulse)
`ifdef ACCID_DEMUX_ERR_CNT_EN
        ,
        .bad_id_count (bad_id_count)
`endif
    );

    always #5 clk = ~clk;

    // cycle counter used for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // output monitor / scoreboard, sampled on the falling edge
    initial begin
        logic [NA-1:0] pv;
        logic [NA-1:0] pr;
        logic [63:0]   pd;
        logic [1:0]    pdst;
        logic          pl;
        bit            pvld;
        beat_t         e;
        pvld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pvld = 1'b0;
            end else begin
                if (tog_en && !S_AXIS_tready) saw_full = 1'b1;
                chk("onehot", 128'($countones(M_AXIS_tvalid) <= 1), 128'(1));
                if (pvld && ((pv & ~pr) != '0))
                    chk("stable", {M_AXIS_tvalid, M_AXIS_tdata[63:0], M_AXIS_tdest[1:0], M_AXIS_tlast[0]},
                        {pv, pd, pdst, pl});
                for (int k = 0; k < NA; k++) begin
                    if (M_AXIS_tvalid[k] && M_AXIS_tready[k]) begin
                        hs_q.push_back(cyc);
                        chk("queue_nonempty", 128'(exp_q.size() != 0), 128'(1));
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            chk("beat", {4'(k), M_AXIS_tdata[k*64 +: 64], M_AXIS_tdest[k*2 +: 2], M_AXIS_tlast[k]}, e);
                        end
                    end
                end
                if (bad_id_pulse) bad_seen++;
                pv = M_AXIS_tvalid; pr = M_AXIS_tready;
                pd = M_AXIS_tdata[63:0]; pdst = M_AXIS_tdest[1:0]; pl = M_AXIS_tlast[0];
                pvld = 1'b1;
            end
        end
    end

    task automatic tick_tog();
        if (tog_en) begin
            M_AXIS_tready[0] = tog_pat[tog_idx % 4];
            tog_idx++;
        end
    endtask

    task automatic send(input logic [IW-1:0] id, input logic [63:0] d, input logic [1:0] dst,
                        input logic l, input bit expect_out, input int port);
        bit rdy;
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tid = id; S_AXIS_tdata = d; S_AXIS_tdest = dst; S_AXIS_tlast = l;
        if (expect_out) exp_q.push_back(beat_t'{4'(port), d, dst, l});
        rdy = 1'b0;
        for (int i = 0; i < 100 && !rdy; i++) begin
            @(negedge clk);
            rdy = S_AXIS_tready;
            @(posedge clk); #1;
            tick_tog();
        end
        chk("accept", 128'(rdy), 128'(1));
    endtask

    task automatic drain();
        S_AXIS_tvalid = 1'b0;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || M_AXIS_tvalid != '0); i++) begin
            @(posedge clk); #1;
            tick_tog();
        end
        chk("drained", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int t0;
        int b0;
        rst = 1'b1;
        S_AXIS_tvalid = 1'b0; S_AXIS_tdata = 64'd0; S_AXIS_tdest = 2'd0;
        S_AXIS_tid = '0; S_AXIS_tlast = 1'b0;
        M_AXIS_tready = '1;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 128'(S_AXIS_tready), 128'(0));
        chk("rst_tvalid", 128'(M_AXIS_tvalid), 128'(0));
        chk("rst_tdata", 128'(M_AXIS_tdata), 128'(0));
        chk("rst_tdest_tlast", 128'({M_AXIS_tdest, M_AXIS_tlast}), 128'(0));
        chk("rst_bad_pulse", 128'(bad_id_pulse), 128'(0));
`ifdef ACCID_DEMUX_ERR_CNT_EN
        chk("rst_bad_count", 128'(bad_id_count), 128'(0));
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("s_tready_after_rst", 128'(S_AXIS_tready), 128'(1));
        @(posedge clk); #1;

        // 3-beat packet to port 2, latency 2, back-to-back beats
        hs_q.delete();
        t0 = cyc;
        send(3'd2, 64'hA000_0000_0000_0001, 2'd1, 1'b0, 1'b1, 2);
        send(3'd2, 64'hA000_0000_0000_0002, 2'd2, 1'b0, 1'b1, 2);
        send(3'd2, 64'hA000_0000_0000_0003, 2'd3, 1'b1, 1'b1, 2);
        drain();
        chk("p3_count", 128'(hs_q.size()), 128'(3));
        chk("p3_first_lat", 128'(hs_q[0]), 128'(t0 + 2));
        chk("p3_last_lat", 128'(hs_q[2]), 128'(t0 + 4));

        // tid ignored after first beat
        send(3'd1, 64'hB000_0000_0000_0001, 2'd0, 1'b0, 1'b1, 1);
        send(3'd3, 64'hB000_0000_0000_0002, 2'd1, 1'b0, 1'b1, 1);
        send(3'd3, 64'hB000_0000_0000_0003, 2'd2, 1'b1, 1'b1, 1);
        drain();

        // back-to-back single-beat packets to ports 0..3, no bubbles
        hs_q.delete();
        t0 = cyc;
        for (int p = 0; p < 4; p++)
            send(3'(p), 64'hC000_0000_0000_0000 + 64'(p), 2'(p), 1'b1, 1'b1, p);
        drain();
        chk("b2b_count", 128'(hs_q.size()), 128'(4));
        chk("b2b_first", 128'(hs_q[0]), 128'(t0 + 2));
        chk("b2b_last", 128'(hs_q[3]), 128'(t0 + 5));

        // out-of-range tid dropped, next packet delivered
        b0 = bad_seen;
        for (int i = 0; i < 4; i++)
            send(3'd5, 64'hD000_0000_0000_0000 + 64'(i), 2'd3, (i == 3), 1'b0, 0);
        send(3'd0, 64'hE000_0000_0000_0001, 2'd1, 1'b0, 1'b1, 0);
        send(3'd0, 64'hE000_0000_0000_0002, 2'd2, 1'b1, 1'b1, 0);
        drain();
        chk("drop_pulses", 128'(bad_seen - b0), 128'(1));
        // single-beat bad packet straight into a good one
        send(3'd6, 64'hF000_0000_0000_0006, 2'd0, 1'b1, 1'b0, 0);
        send(3'd3, 64'hF000_0000_0000_0003, 2'd2, 1'b1, 1'b1, 3);
        drain();
        chk("drop1_pulses", 128'(bad_seen - b0), 128'(2));
`ifdef ACCID_DEMUX_ERR_CNT_EN
        chk("bad_count", 128'(bad_id_count), 128'(2));
`endif

        // backpressure on port 0 with tready pattern 1,0,0,1
        tog_idx = 0;
        tog_en = 1'b1;
        for (int i = 0; i < 8; i++)
            send(3'd0, 64'h1111_0000_0000_0000 + 64'(i), 2'(i), (i == 7), 1'b1, 0);
        drain();
        tog_en = 1'b0;
        M_AXIS_tready = '1;
        chk("skid_full_seen", 128'(saw_full), 128'(1));

        // reset in the middle of a 5-beat packet
        for (int i = 0; i < 3; i++)
            send(3'd2, 64'h2222_0000_0000_0000 + 64'(i), 2'd0, 1'b0, 1'b1, 2);
        rst = 1'b1;
        S_AXIS_tvalid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_tvalid", 128'(M_AXIS_tvalid), 128'(0));
        chk("mid_rst_s_tready", 128'(S_AXIS_tready), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(3'd1, 64'h3333_0000_0000_0001, 2'd1, 1'b0, 1'b1, 1);
        send(3'd1, 64'h3333_0000_0000_0002, 2'd2, 1'b1, 1'b1, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsc_axis_accid_demux.md
BSC_AXIS_ACCID_DEMUX -- requirements
Module: bsc_axis_accID_demux

Interface
REQ-001 SHALL have parameter NUM_ACCS, default 4, number of accelerator output ports (legal range 2..16).
REQ-002 SHALL have parameter ID_WIDTH, default 2, width of tid (legal when 2^ID_WIDTH >= NUM_ACCS).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all logic on rising edge); rst input 1 (synchronous, active-high).
REQ-004 SHALL have S_AXIS_tdata input 64 (incoming data), S_AXIS_tdest input 2, S_AXIS_tid input ID_WIDTH (target accelerator), S_AXIS_tlast input 1, S_AXIS_tvalid input 1, S_AXIS_tready output 1.
REQ-005 SHALL have M_AXIS_tdata output NUM_ACCS*64, and M_AXIS_tdest output NUM_ACCS*2; port k occupies slice k.
REQ-006 SHALL have M_AXIS_tlast, M_AXIS_tvalid output NUM_ACCS, and M_AXIS_tready input NUM_ACCS; bit k belongs to port k.
REQ-007 SHALL have bad_id_pulse output 1: one-cycle pulse per dropped packet.

Function
REQ-008 SHALL route each packet to port k = tid sampled on its first beat, strip tid, and forward tdata/tdest/tlast unchanged.
REQ-009 SHALL ignore tid on non-first beats; the whole packet up to tlast goes to the latched port.
REQ-010 SHALL buffer input in a 2-entry skid buffer; S_AXIS_tready = buffer not full, registered (no combinational path from M_AXIS_tready).
REQ-011 SHALL drive outputs from one output register; latency from an input beat accepted into an empty block to M_AXIS_tvalid[k] is 2 cycles.
REQ-012 SHALL sustain 1 beat/cycle when the selected M_AXIS_tready stays high.
REQ-013 SHALL assert at most one M_AXIS_tvalid bit at a time; data/tdest/tlast are shared to all slices, and only tvalid is gated.
REQ-014 SHALL hold output contents stable while tvalid[k]=1 and tready[k]=0.
REQ-015 FSM states: IDLE (awaiting first beat), ROUTE (forwarding to latched port), DROP (discarding).
REQ-016 IDLE->ROUTE on first beat with tid<NUM_ACCS; IDLE->DROP on first beat with tid>=NUM_ACCS, pulsing bad_id_pulse that cycle.
REQ-017 ROUTE->IDLE when the tlast beat leaves the output register; DROP->IDLE when the tlast beat is consumed from the skid buffer.
REQ-018 Single-beat packet (tlast on first beat) SHALL route or drop correctly and return to IDLE without an idle cycle.
REQ-019 In DROP, SHALL consume beats at 1/cycle regardless of any M_AXIS_tready, asserting no M_AXIS_tvalid.
REQ-020 Next packet's first beat MAY enter the output register in the same cycle the previous tlast beat is handshaken out.

Reset
REQ-021 While rst=1: FSM=IDLE, skid buffer empty, S_AXIS_tready=0, all M_AXIS_tvalid=0, bad_id_pulse=0, error counter=0.
REQ-022 S_AXIS_tready SHALL rise in the first cycle after rst deasserts.
REQ-023 Reset mid-packet SHALL discard buffered beats and the partial packet; the first beat after reset is treated as a packet start.
REQ-024 M_AXIS_tdata/tdest/tlast SHALL reset to 0.

Configuration
REQ-025 Macro ACCID_DEMUX_ERR_CNT_EN: when defined, add output bad_id_count (16 bits), a count of dropped packets that saturates at 0xFFFF and resets to 0.
REQ-026 Without ACCID_DEMUX_ERR_CNT_EN, bad_id_count port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-027 NUM_ACCS=4: 3-beat packet with tid=2 and all tready=1 -> tvalid[2] high 3 consecutive cycles starting 2 cycles after the first input beat, with tlast on the 3rd beat; other tvalid bits stay 0.
REQ-028 tid=1 on beat 0, tid=3 on beats 1-2 -> all 3 beats on port 1.
REQ-029 NUM_ACCS=3, tid=3 with 4 beats -> no M tvalid, bad_id_pulse once, bad_id_count=1 (macro on); next packet with tid=0 is delivered normally.
REQ-030 Back-to-back 1-beat packets with tid 0,1,2,3 and tready=1 -> one beat per cycle on ports 0,1,2,3 in order, with no bubbles.
REQ-031 tready[0] toggles 1,0,0,1 during an 8-beat packet -> no loss or duplication, data stable while stalled, S_AXIS_tready falls once the skid buffer is full.
REQ-032 rst pulsed after beat 2 of a 5-beat packet -> tvalid=0 next cycle; a new packet with tid=1 routes to port 1.
